// File: rtl/gpio_edge_irq_pkg.sv
// gpio_edge_irq shared definitions.
// Register map constants and the edge-to-status helper.
package gpio_edge_irq_pkg;

  localparam int GPIO_W = 8;

  localparam logic [2:0] ADR_DATA = 3'd0;
  localparam logic [2:0] ADR_RISE = 3'd1;
  localparam logic [2:0] ADR_FALL = 3'd2;
  localparam logic [2:0] ADR_STAT = 3'd3;
  localparam logic [2:0] ADR_DBP  = 3'd4;

  function automatic logic [GPIO_W-1:0] edge_set(
    input logic [GPIO_W-1:0] cur,
    input logic [GPIO_W-1:0] prev,
    input logic [GPIO_W-1:0] rise,
    input logic [GPIO_W-1:0] fall
  );
    return (cur & ~prev & rise) | (~cur & prev & fall);
  endfunction

endpackage

// File: rtl/gpio_sync2.sv
// gpio_sync2: two-flop synchronizer for asynchronous inputs.
// Each bit passes through two wb-clock flops before use.
module gpio_sync2 #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  logic [width-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gpio_edge_irq.sv
// gpio_edge_irq: Wishbone GPIO edge detector with level interrupt.
// Optional debounce filter enabled by GPIO_EDGE_IRQ_DEBOUNCE_EN.
module gpio_edge_irq
  import gpio_edge_irq_pkg::*;
#(
  parameter int gpio_width   = 8,
  parameter int wb_dat_width = 8,
  parameter int wb_adr_width = 3
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic [wb_adr_width-1:0] wb_adr_i,
  input  logic [wb_dat_width-1:0] wb_dat_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic [2:0]              wb_cti_i,
  input  logic [1:0]              wb_bte_i,
  output logic [wb_dat_width-1:0] wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_rty_o,
  input  logic [gpio_width-1:0]   gpio_i,
  output logic                    irq_o
);

  logic [gpio_width-1:0] sync;
  logic [gpio_width-1:0] deb;
  logic [gpio_width-1:0] deb_q;
  logic [gpio_width-1:0] rise_en;
  logic [gpio_width-1:0] fall_en;
  logic [gpio_width-1:0] status;
  logic [gpio_width-1:0] hw_set;
  logic [gpio_width-1:0] w1c;
  logic [gpio_width-1:0] dbp_rd;
  logic [wb_dat_width-1:0] rd_dat;
  logic wr;
  logic unused_ok;

  assign unused_ok = ^{wb_cyc_i, wb_cti_i, wb_bte_i};
  assign wb_err_o  = 1'b0;
  assign wb_rty_o  = 1'b0;

  gpio_sync2 #(
    .width(gpio_width)
  ) u_sync (
    .clk  (wb_clk),
    .rst_n(wb_rst),
    .d    (gpio_i),
    .q    (sync)
  );

  assign wr = wb_stb_i & wb_we_i & ~wb_ack_o;

`ifdef GPIO_EDGE_IRQ_DEBOUNCE_EN
  logic [7:0] db_period;
  logic [7:0] presc;
  logic [gpio_width-1:0] smp;
  logic [gpio_width-1:0] deb_r;
  logic [gpio_width-1:0] agree;
  logic tick;

  assign tick  = (presc == 8'd0);
  assign agree = ~(sync ^ smp);

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      db_period <= '0;
      presc     <= '0;
      smp       <= '0;
      deb_r     <= '0;
    end else begin
      if (wr && wb_adr_i == ADR_DBP)
        db_period <= wb_dat_i;
      // new period takes effect at the next reload only
      presc <= tick ? db_period : presc - 8'd1;
      if (tick) begin
        smp   <= sync;
        deb_r <= (deb_r & ~agree) | (sync & agree);
      end
    end
  end

  assign deb    = deb_r;
  assign dbp_rd = db_period;
`else
  assign deb    = sync;
  assign dbp_rd = '0;
`endif

  assign hw_set = edge_set(deb, deb_q, rise_en, fall_en);
  assign w1c    = (wr && wb_adr_i == ADR_STAT) ? wb_dat_i : '0;

  always_comb begin
    rd_dat = '0;
    unique case (1'b1)
      (wb_adr_i == ADR_DATA): rd_dat = deb;
      (wb_adr_i == ADR_RISE): rd_dat = rise_en;
      (wb_adr_i == ADR_FALL): rd_dat = fall_en;
      (wb_adr_i == ADR_STAT): rd_dat = status;
      (wb_adr_i == ADR_DBP):  rd_dat = dbp_rd;
      default:                rd_dat = '0;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst) begin
    if (!wb_rst) begin
      deb_q    <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      status   <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      deb_q    <= deb;
      wb_ack_o <= wb_stb_i & ~wb_ack_o;
      wb_dat_o <= rd_dat;
      if (wr && wb_adr_i == ADR_RISE)
        rise_en <= wb_dat_i;
      if (wr && wb_adr_i == ADR_FALL)
        fall_en <= wb_dat_i;
      // hardware set wins over a same-cycle clear
      status <= (status & ~w1c) | hw_set;
    end
  end

  assign irq_o = |status;

endmodule

// File: tb/tb_gpio_edge_irq.sv
// tb_gpio_edge_irq: table vectors, corner sequences and a
// randomized run against a pin-history status model.
module tb_gpio_edge_irq;

  logic       wb_clk = 1'b0;
  logic       wb_rst = 1'b0;
  logic [2:0] wb_adr_i = '0;
  logic [7:0] wb_dat_i = '0;
  logic       wb_we_i = 1'b0;
  logic       wb_cyc_i = 1'b0;
  logic       wb_stb_i = 1'b0;
  logic [2:0] wb_cti_i = '0;
  logic [1:0] wb_bte_i = '0;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  logic       wb_err_o;
  logic       wb_rty_o;
  logic [7:0] gpio_i = '0;
  logic       irq_o;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef GPIO_EDGE_IRQ_DEBOUNCE_EN
  localparam int SETTLE = 12;
  localparam logic [7:0] DBP_EXP = 8'h55;
`else
  localparam int SETTLE = 5;
  localparam logic [7:0] DBP_EXP = 8'h00;
`endif

  gpio_edge_irq dut (
    .wb_clk  (wb_clk),
    .wb_rst  (wb_rst),
    .wb_adr_i(wb_adr_i),
    .wb_dat_i(wb_dat_i),
    .wb_we_i (wb_we_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i),
    .wb_cti_i(wb_cti_i),
    .wb_bte_i(wb_bte_i),
    .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o),
    .wb_err_o(wb_err_o),
    .wb_rty_o(wb_rty_o),
    .gpio_i  (gpio_i),
    .irq_o   (irq_o)
  );

  always #5 wb_clk = ~wb_clk;

  typedef struct {
    logic [2:0] adr;
    logic       we;
    logic [7:0] dat;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  task automatic wb_xfer(input logic [2:0] adr, input logic we,
                         input logic [7:0] dat, output logic [7:0] rd,
                         output int lat);
    int k;
    @(posedge wb_clk);
    #1;
    wb_adr_i = adr;
    wb_we_i  = we;
    wb_dat_i = dat;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    k = 0;
    do begin
      @(posedge wb_clk);
      #1;
      k++;
    end while (!wb_ack_o && k < 8);
    chk("ack_seen", wb_ack_o, 1'b1);
    rd  = wb_dat_o;
    lat = k;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic wr(input logic [2:0] adr, input logic [7:0] dat);
    logic [7:0] d;
    int l;
    wb_xfer(adr, 1'b1, dat, d, l);
  endtask

  task automatic rd(input logic [2:0] adr, output logic [7:0] d);
    int l;
    wb_xfer(adr, 1'b0, 8'h00, d, l);
  endtask

  vec_t vecs[18];
  logic [7:0] d;
  logic [7:0] m_stat, m_pins, m_rise, m_fall, nv, mask;
  int lat;

  initial begin
    vecs[0]  = '{3'd1, 1'b1, 8'hA5, 8'h00};
    vecs[1]  = '{3'd1, 1'b0, 8'h00, 8'hA5};
    vecs[2]  = '{3'd2, 1'b1, 8'h3C, 8'h00};
    vecs[3]  = '{3'd2, 1'b0, 8'h00, 8'h3C};
    vecs[4]  = '{3'd0, 1'b0, 8'h00, 8'h00};
    vecs[5]  = '{3'd5, 1'b1, 8'hFF, 8'h00};
    vecs[6]  = '{3'd5, 1'b0, 8'h00, 8'h00};
    vecs[7]  = '{3'd6, 1'b0, 8'h00, 8'h00};
    vecs[8]  = '{3'd7, 1'b1, 8'hFF, 8'h00};
    vecs[9]  = '{3'd7, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{3'd4, 1'b1, 8'h55, 8'h00};
    vecs[11] = '{3'd4, 1'b0, 8'h00, DBP_EXP};
    vecs[12] = '{3'd1, 1'b1, 8'hFF, 8'h00};
    vecs[13] = '{3'd2, 1'b1, 8'hFF, 8'h00};
    vecs[14] = '{3'd3, 1'b0, 8'h00, 8'h00};
    vecs[15] = '{3'd1, 1'b1, 8'h00, 8'h00};
    vecs[16] = '{3'd2, 1'b1, 8'h00, 8'h00};
    vecs[17] = '{3'd4, 1'b1, 8'h00, 8'h00};

    repeat (3) @(posedge wb_clk);
    #1;
    chk("rst_ack", wb_ack_o, 1'b0);
    chk("rst_dat", wb_dat_o, 8'h00);
    chk("rst_irq", irq_o, 1'b0);
    chk("rst_err_rty", {wb_err_o, wb_rty_o}, 2'b00);
    wb_rst = 1'b1;
    idle(2);

    for (int i = 0; i < 18; i++) begin
      wb_xfer(vecs[i].adr, vecs[i].we, vecs[i].dat, d, lat);
      if (!vecs[i].we)
        chk($sformatf("vec%0d_rd", i), d, vecs[i].exp);
    end
    chk("no_replay_irq", irq_o, 1'b0);

    // single rise on bit 0, then clear
    wr(3'd1, 8'h01);
    wr(3'd2, 8'h00);
    gpio_i = 8'h01;
    idle(SETTLE);
    rd(3'd3, d);
    chk("rise_stat", d, 8'h01);
    chk("rise_irq", irq_o, 1'b1);
    wr(3'd3, 8'h01);
    rd(3'd3, d);
    chk("w1c_stat", d, 8'h00);
    chk("w1c_irq", irq_o, 1'b0);

    // fall on bit 7 only
    wr(3'd1, 8'h00);
    wr(3'd2, 8'h80);
    gpio_i = 8'hFF;
    idle(SETTLE);
    rd(3'd3, d);
    chk("fall_pre", d, 8'h00);
    gpio_i = 8'h7F;
    idle(SETTLE);
    rd(3'd3, d);
    chk("fall_stat", d, 8'h80);
    gpio_i = 8'hFF;
    idle(SETTLE);
    rd(3'd3, d);
    chk("fall_rise_ign", d, 8'h80);
    wr(3'd3, 8'hFF);
    wr(3'd2, 8'h00);

    // W1C racing a hardware set on bit 1
    gpio_i = 8'h00;
    idle(SETTLE);
    wr(3'd1, 8'h03);
    gpio_i = 8'h01;
    idle(SETTLE);
    rd(3'd3, d);
    chk("race_pre", d, 8'h01);
    gpio_i = 8'h03;
    idle(2);
`ifdef GPIO_EDGE_IRQ_DEBOUNCE_EN
    idle(2);
`endif
    wb_adr_i = 3'd3;
    wb_we_i  = 1'b1;
    wb_dat_i = 8'h03;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    idle(1);
    chk("race_ack", wb_ack_o, 1'b1);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    rd(3'd3, d);
    chk("race_stat", d, 8'h02);
    wr(3'd3, 8'hFF);
    wr(3'd1, 8'h00);

    // empty address, single ack, then streaming acks
    wb_xfer(3'd6, 1'b0, 8'h00, d, lat);
    chk("adr6_rd", d, 8'h00);
    chk("adr6_lat", lat, 1);
    idle(1);
    chk("adr6_one_ack", wb_ack_o, 1'b0);
    wb_adr_i = 3'd6;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      chk($sformatf("alt_ack%0d", i), wb_ack_o, (i % 2 == 0));
    end
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    idle(2);

`ifdef GPIO_EDGE_IRQ_DEBOUNCE_EN
    wr(3'd4, 8'd3);
    gpio_i = 8'h00;
    idle(20);
    wr(3'd3, 8'hFF);
    wr(3'd1, 8'h04);
    wr(3'd2, 8'h04);
    gpio_i = 8'h04;
    idle(2);
    gpio_i = 8'h00;
    idle(20);
    rd(3'd0, d);
    chk("glitch_deb", d, 8'h00);
    rd(3'd3, d);
    chk("glitch_stat", d, 8'h00);
    gpio_i = 8'h04;
    idle(12);
    rd(3'd0, d);
    chk("held_deb", d, 8'h04);
    rd(3'd3, d);
    chk("held_stat", d, 8'h04);
    wr(3'd1, 8'h00);
    wr(3'd2, 8'h00);
    wr(3'd4, 8'h00);
    idle(20);
    wr(3'd3, 8'hFF);
`endif

    // randomized pins and enables against a pin-history model
    gpio_i = 8'h00;
    idle(SETTLE);
    wr(3'd3, 8'hFF);
    m_stat = 8'h00;
    m_pins = 8'h00;
    m_rise = 8'h00;
    m_fall = 8'h00;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        m_rise = 8'($urandom);
        m_fall = 8'($urandom);
        wr(3'd1, m_rise);
        wr(3'd2, m_fall);
      end
      nv = ($urandom_range(0, 3) == 0) ? m_pins : 8'($urandom);
      gpio_i = nv;
      idle(SETTLE);
      for (int b = 0; b < 8; b++) begin
        if (nv[b] && !m_pins[b] && m_rise[b]) m_stat[b] = 1'b1;
        if (!nv[b] && m_pins[b] && m_fall[b]) m_stat[b] = 1'b1;
      end
      m_pins = nv;
      rd(3'd3, d);
      chk($sformatf("rnd%0d_stat", i), d, m_stat);
      rd(3'd0, d);
      chk($sformatf("rnd%0d_pins", i), d, m_pins);
      chk($sformatf("rnd%0d_irq", i), irq_o, (m_stat != 0));
      if ($urandom_range(0, 2) == 0) begin
        mask = 8'($urandom);
        wr(3'd3, mask);
        m_stat = m_stat & ~mask;
      end
    end

    // reset during a pending ack with all status bits set
    wr(3'd1, 8'h00);
    wr(3'd2, 8'h00);
    gpio_i = 8'h00;
    idle(SETTLE);
    wr(3'd3, 8'hFF);
    wr(3'd1, 8'hFF);
    gpio_i = 8'hFF;
    idle(SETTLE);
    rd(3'd3, d);
    chk("pre_rst_stat", d, 8'hFF);
    @(posedge wb_clk);
    #1;
    wb_adr_i = 3'd3;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    idle(1);
    chk("pre_rst_ack", wb_ack_o, 1'b1);
    #2;
    wb_rst = 1'b0;
    #1;
    chk("async_irq", irq_o, 1'b0);
    chk("async_ack", wb_ack_o, 1'b0);
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    idle(2);
    wb_rst = 1'b1;
    idle(SETTLE);
    chk("post_rst_irq", irq_o, 1'b0);
    rd(3'd1, d);
    chk("post_rst_rise", d, 8'h00);
    rd(3'd3, d);
    chk("post_rst_stat", d, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule
